power_ctrl_multi: RTL and testbench

Per-compute-unit clock/reset sequencer for the e-GPU. It replaces the fixed start/sleep gating with a parametrised controller that provides:
- a per-CU state machine with reset hold, drain and retention sleep;
- selectable retention versus full-off power-down;
- wake-up from retention without re-reset;
- L2 clock gating with an idle hysteresis.

It sits between the config register block, which supplies start/mask/mode, and the CU/L2 clock-gate and reset inputs.

---
 rtl/power_ctrl_multi.sv | 168 ++++++++++++++++
 tb/tb_power_ctrl_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/power_ctrl_multi.sv
// Per-CU clock/reset sequencer with retention sleep, drain handling and
// L2 clock gating behind an idle hysteresis counter.

module power_ctrl_cu #(
  parameter int RST_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic sleep_req_i,
  input  logic delay_sleep_i,
  input  logic wake_i,
  input  logic retain_i,
  output logic active_d_o,
  output logic off_d_o,
  output logic clk_en_o,
  output logic rst_n_o
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {CU_OFF, CU_INIT, CU_RUN, CU_DRAIN, CU_SLEEP} cu_state_e;

  cu_state_e      state_q, state_d;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic           clk_en_q, rst_n_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CU_OFF;
      rcnt_q   <= '0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      clk_en_q <= active_d_o;
      rst_n_q  <= (state_d != CU_OFF) && (state_d != CU_INIT);
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      CU_OFF: if (start_i) begin
        state_d = CU_INIT;
        rcnt_d  = RST_LOAD;
      end
      // Counter holds at zero; the exit happens on the cycle it is seen at zero.
      CU_INIT: if (rcnt_q == '0) state_d = CU_RUN;
               else rcnt_d = rcnt_q - RW'(1);
      CU_RUN: if (sleep_req_i) begin
        if (delay_sleep_i) state_d = CU_DRAIN;
        else               state_d = retain_i ? CU_SLEEP : CU_OFF;
      end
      CU_DRAIN: if (!delay_sleep_i) state_d = retain_i ? CU_SLEEP : CU_OFF;
      CU_SLEEP: if (wake_i || start_i) state_d = CU_RUN;
                else if (!retain_i)    state_d = CU_OFF;
      default: state_d = CU_OFF;
    endcase
    active_d_o = (state_d == CU_INIT) || (state_d == CU_RUN) || (state_d == CU_DRAIN);
    off_d_o    = (state_d == CU_OFF);
  end

  assign clk_en_o = clk_en_q;
  assign rst_n_o  = rst_n_q;
endmodule

module power_ctrl_multi #(
  parameter int NUM_CU         = 4,
  parameter int RST_CYCLES     = 4,
  parameter int L2_IDLE_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          gpu_start_i,
  input  logic [NUM_CU-1:0]             cu_mask_i,
  input  logic                          retain_i,
  input  logic [NUM_CU-1:0]             cu_sleep_req_i,
  input  logic [NUM_CU-1:0]             cu_delay_sleep_i,
  input  logic [NUM_CU-1:0]             cu_wake_i,
  output logic [NUM_CU-1:0]             cu_clk_en_o,
  output logic [NUM_CU-1:0]             cu_rst_n_o,
  output logic                          l2_clk_en_o,
  output logic                          l2_rst_n_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(NUM_CU+1)-1:0]   active_count_o
);
  localparam int CNT_W  = $clog2(NUM_CU + 1);
  localparam int IDLE_W = $clog2(L2_IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(L2_IDLE_CYCLES);

  typedef enum logic [1:0] {L2_OFF, L2_ON, L2_GATED} l2_state_e;

  logic [NUM_CU-1:0] act_d, off_d;
  logic              busy_q, busy_d, done_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  l2_state_e         l2_q, l2_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              l2_clk_q, l2_rstn_q;

  for (genvar g = 0; g < NUM_CU; g++) begin : g_cu
    power_ctrl_cu #(.RST_CYCLES(RST_CYCLES)) u_cu (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (gpu_start_i & cu_mask_i[g]),
      .sleep_req_i   (cu_sleep_req_i[g]),
      .delay_sleep_i (cu_delay_sleep_i[g]),
      .wake_i        (cu_wake_i[g]),
      .retain_i      (retain_i),
      .active_d_o    (act_d[g]),
      .off_d_o       (off_d[g]),
      .clk_en_o      (cu_clk_en_o[g]),
      .rst_n_o       (cu_rst_n_o[g])
    );
  end

  always_comb begin
    busy_d = |act_d;
    cnt_d  = '0;
    for (int i = 0; i < NUM_CU; i++) cnt_d = cnt_d + CNT_W'(act_d[i]);
  end

  // L2 follows CU next-state so its clock is never behind a CU clock enable.
  always_comb begin
    l2_d   = l2_q;
    idle_d = idle_q;
    if (busy_d) begin
      l2_d   = L2_ON;
      idle_d = '0;
    end else begin
      case (l2_q)
        L2_ON: if (idle_q == IDLE_MAX) l2_d = (&off_d) ? L2_OFF : L2_GATED;
               else idle_d = idle_q + IDLE_W'(1);
        L2_GATED: if (&off_d) l2_d = L2_OFF;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      l2_q      <= L2_OFF;
      idle_q    <= '0;
      l2_clk_q  <= 1'b0;
      l2_rstn_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= busy_q & ~busy_d;
      cnt_q     <= cnt_d;
      l2_q      <= l2_d;
      idle_q    <= idle_d;
      l2_clk_q  <= (l2_d == L2_ON);
      l2_rstn_q <= (l2_d != L2_OFF);
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign active_count_o = cnt_q;
  assign l2_clk_en_o    = l2_clk_q;
  assign l2_rst_n_o     = l2_rstn_q;
endmodule

// File: tb/tb_power_ctrl_multi.sv
// Directed bench for power_ctrl_multi: a vector table for CU sequencing plus
// hand-written sequences for L2 hysteresis, retention-off and async reset.

module tb_power_ctrl_multi;
  logic       clk, rst, start, retain;
  logic [3:0] mask, slp, dly, wk;
  logic [3:0] cu_clk, cu_rstn;
  logic       l2c, l2r, busy, done;
  logic [2:0] cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  power_ctrl_multi #(.NUM_CU(4), .RST_CYCLES(4), .L2_IDLE_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .gpu_start_i(start), .cu_mask_i(mask),
    .retain_i(retain), .cu_sleep_req_i(slp), .cu_delay_sleep_i(dly),
    .cu_wake_i(wk), .cu_clk_en_o(cu_clk), .cu_rst_n_o(cu_rstn),
    .l2_clk_en_o(l2c), .l2_rst_n_o(l2r), .busy_o(busy), .done_o(done),
    .active_count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] mask, slp, dly, wk;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [14:0] eo(logic [3:0] c, logic [3:0] r, logic lc, logic lr,
                                     logic b, logic d, logic [2:0] n);
    return {c, r, lc, lr, b, d, n};
  endfunction

  function automatic vec_t mv(logic s, logic [3:0] m, logic [3:0] sl, logic [3:0] dl,
                              logic [3:0] w, logic [14:0] e);
    vec_t v;
    v.st = s; v.mask = m; v.slp = sl; v.dly = dl; v.wk = w; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [14:0] exp);
    logic [14:0] act;
    act = {cu_clk, cu_rstn, l2c, l2r, busy, done, cnt};
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got clk=%b rstn=%b l2=%b%b busy=%b done=%b cnt=%0d, expected clk=%b rstn=%b l2=%b%b busy=%b done=%b cnt=%0d",
                  nm, act[14:11], act[10:7], act[6], act[5], act[4], act[3], act[2:0],
                  exp[14:11], exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
  endtask

  // Apply inputs, take one edge, sample 1ns later.
  task automatic step(input logic s, input logic [3:0] m, input logic r,
                      input logic [3:0] sl, input logic [3:0] dl, input logic [3:0] w);
    start = s; mask = m; retain = r; slp = sl; dly = dl; wk = w;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [14:0] e_run2, e_sl0;

  initial begin
    rst = 1'b1; start = 0; mask = 0; retain = 1; slp = 0; dly = 0; wk = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    rst = 1'b0;

    e_run2 = eo(4'b0101, 4'b0101, 1, 1, 1, 0, 2);
    e_sl0  = eo(4'b0100, 4'b0101, 1, 1, 1, 0, 1);
    vecs[0]  = mv(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, eo(4'b0101, 4'b0000, 1, 1, 1, 0, 2));
    vecs[1]  = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, eo(4'b0101, 4'b0000, 1, 1, 1, 0, 2));
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, e_run2);
    vecs[5]  = mv(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, e_run2);
    vecs[6]  = mv(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, e_run2);
    vecs[7]  = mv(0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, e_run2);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = mv(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, e_sl0);
    for (int i = 11; i < 15; i++)
      vecs[i] = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, e_sl0);
    vecs[15] = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, e_run2);
    vecs[16] = mv(0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, e_sl0);
    vecs[17] = mv(0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, e_run2);
    vecs[18] = mv(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, e_sl0);
    vecs[19] = mv(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, e_run2);
    vecs[20] = mv(1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, eo(4'b1111, 4'b0101, 1, 1, 1, 0, 4));
    vecs[21] = mv(0, 4'b0000, 4'b1010, 4'b0000, 4'b0000, eo(4'b1111, 4'b0101, 1, 1, 1, 0, 4));
    vecs[22] = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, eo(4'b1111, 4'b0101, 1, 1, 1, 0, 4));
    vecs[23] = mv(0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, eo(4'b1111, 4'b0101, 1, 1, 1, 0, 4));
    vecs[24] = mv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, eo(4'b1111, 4'b1111, 1, 1, 1, 0, 4));

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].st, vecs[i].mask, 1'b1, vecs[i].slp, vecs[i].dly, vecs[i].wk);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Full-off sleep of all CUs: done pulse, then L2 off exactly 16 cycles later.
    step(0, 4'h0, 0, 4'b1111, 4'h0, 4'h0);
    chk("alloff_done", eo(4'b0000, 4'b0000, 1, 1, 0, 1, 0));
    for (int k = 1; k <= 17; k++) begin
      step(0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
      chk($sformatf("l2_off_k%0d", k),
          eo(4'b0000, 4'b0000, (k < 16), (k < 16), 0, 0, 0));
    end

    // Retention sleep: L2 gated after 16 cycles, then full off when retain drops.
    step(1, 4'b1111, 1, 4'h0, 4'h0, 4'h0);
    chk("all_init", eo(4'b1111, 4'b0000, 1, 1, 1, 0, 4));
    for (int k = 0; k < 3; k++) step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("all_init_hold", eo(4'b1111, 4'b0000, 1, 1, 1, 0, 4));
    step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("all_run", eo(4'b1111, 4'b1111, 1, 1, 1, 0, 4));
    step(0, 4'h0, 1, 4'b1111, 4'h0, 4'h0);
    chk("all_sleep", eo(4'b0000, 4'b1111, 1, 1, 0, 1, 0));
    for (int k = 1; k <= 16; k++) begin
      step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
      chk($sformatf("l2_gate_k%0d", k), eo(4'b0000, 4'b1111, (k < 16), 1, 0, 0, 0));
    end
    step(0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    chk("retain_drop", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));

    // Start coinciding with the idle threshold keeps L2 on.
    step(1, 4'b0001, 1, 4'h0, 4'h0, 4'h0);
    chk("c0_init", eo(4'b0001, 4'b0000, 1, 1, 1, 0, 1));
    for (int k = 0; k < 4; k++) step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("c0_run", eo(4'b0001, 4'b0001, 1, 1, 1, 0, 1));
    step(0, 4'h0, 1, 4'b0001, 4'h0, 4'h0);
    chk("c0_sleep", eo(4'b0000, 4'b0001, 1, 1, 0, 1, 0));
    for (int k = 1; k < 16; k++) step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("c0_pre_thresh", eo(4'b0000, 4'b0001, 1, 1, 0, 0, 0));
    step(1, 4'b0001, 1, 4'h0, 4'h0, 4'h0);
    chk("start_at_thresh", eo(4'b0001, 4'b0001, 1, 1, 1, 0, 1));
    step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("start_at_thresh_hold", eo(4'b0001, 4'b0001, 1, 1, 1, 0, 1));

    // Async reset with CU0 in DRAIN and CU1 in INIT.
    do_reset();
    chk("rst_clean", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    step(1, 4'b0001, 1, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("d_run", eo(4'b0001, 4'b0001, 1, 1, 1, 0, 1));
    step(1, 4'b0010, 1, 4'b0001, 4'b0001, 4'h0);
    chk("d_drain_init", eo(4'b0011, 4'b0001, 1, 1, 1, 0, 2));
    #3 rst = 1'b1;
    #1 chk("async_rst", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("rst_held", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step(0, 4'h0, 1, 4'b0001, 4'b0001, 4'b1111);
    chk("post_rst_idle", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    step(0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    chk("post_rst_nodone", eo(4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    step(1, 4'b0100, 1, 4'h0, 4'h0, 4'h0);
    chk("post_rst_start", eo(4'b0100, 4'b0000, 1, 1, 1, 0, 1));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
